// File: rtl/slave_in_port_burst_if.sv
// Bus bundle between the interconnect master and slave_in_port_burst.
// master modport: drives the request/header lines (master_valid, read_en, write_en, burst,
//                 rx_addr, rx_data) and observes the slave's response lines.
// slave modport:  observes the request/header lines and drives slave_ready, data_out,
//                 addr_out, wr_valid, read_enable, burst_counter, rx_done, addr_err.
interface slave_in_port_burst_if #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned BURST_WIDTH = 12
);
  logic                   master_valid;
  logic                   read_en;
  logic                   write_en;
  logic [BURST_WIDTH-1:0] burst;
  logic                   rx_addr;
  logic                   rx_data;
  logic                   slave_ready;
  logic [DATA_WIDTH-1:0]  data_out;
  logic [ADDR_WIDTH-1:0]  addr_out;
  logic                   wr_valid;
  logic                   read_enable;
  logic [BURST_WIDTH-1:0] burst_counter;
  logic                   rx_done;
  logic                   addr_err;

  modport master (
    output master_valid, read_en, write_en, burst, rx_addr, rx_data,
    input  slave_ready, data_out, addr_out, wr_valid, read_enable, burst_counter, rx_done,
           addr_err
  );

  modport slave (
    input  master_valid, read_en, write_en, burst, rx_addr, rx_data,
    output slave_ready, data_out, addr_out, wr_valid, read_enable, burst_counter, rx_done,
           addr_err
  );
endinterface

// File: rtl/slave_in_port_burst.sv
// Serial slave input port with write/read bursts.
// After a valid/ready handshake it shifts in a serial address (and, for writes, the first data
// beat), then either shifts further write beats or issues one read strobe per cycle, with an
// auto-incrementing (wrapping) address and a range check against MEM_DEPTH.
// Ports:
//   clk   - rising-edge clock
//   reset - synchronous active-high reset
//   bus   - slave modport of slave_in_port_burst_if (handshake, serial inputs, beat outputs)
module slave_in_port_burst #(
  parameter int unsigned ADDR_WIDTH  = 12,
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned BURST_WIDTH = 12,
  parameter int unsigned MEM_DEPTH   = 4096
) (
  input logic                  clk,
  input logic                  reset,
  slave_in_port_burst_if.slave bus
);
  // Counter wide enough for both header (ADDR_WIDTH) and data (DATA_WIDTH <= ADDR_WIDTH) bits.
  localparam int unsigned CntWidth = $clog2(ADDR_WIDTH + 1);
  localparam logic [BURST_WIDTH-1:0] BurstOne = BURST_WIDTH'(1);

  // StLast shows the final strobe, StDone shows rx_done, then back to idle.
  typedef enum logic [2:0] {StIdle, StHdr, StWdata, StRburst, StLast, StDone} state_e;

  state_e                 state_q, state_d;
  logic                   is_wr_q, is_wr_d;
  logic [CntWidth-1:0]    bit_cnt_q, bit_cnt_d;
  logic [ADDR_WIDTH-1:0]  addr_sh_q, addr_sh_d;
  logic [DATA_WIDTH-1:0]  data_sh_q, data_sh_d;
  logic [ADDR_WIDTH-1:0]  next_addr_q, next_addr_d;
  logic [BURST_WIDTH-1:0] rem_q, rem_d;
  logic [DATA_WIDTH-1:0]  data_out_q, data_out_d;
  logic [ADDR_WIDTH-1:0]  addr_out_q, addr_out_d;
  logic [BURST_WIDTH-1:0] burst_counter_q, burst_counter_d;
  logic                   wr_valid_q, wr_valid_d;
  logic                   read_enable_q, read_enable_d;
  logic                   rx_done_q, rx_done_d;
  logic                   addr_err_q, addr_err_d;

  logic                   beat;
  logic [ADDR_WIDTH-1:0]  beat_addr;
  logic [BURST_WIDTH-1:0] beat_rem;
  logic [BURST_WIDTH-1:0] burst_eff;
  logic                   in_range;

  always_comb begin
    state_d         = state_q;
    is_wr_d         = is_wr_q;
    bit_cnt_d       = bit_cnt_q;
    addr_sh_d       = addr_sh_q;
    data_sh_d       = data_sh_q;
    next_addr_d     = next_addr_q;
    rem_d           = rem_q;
    data_out_d      = data_out_q;
    addr_out_d      = addr_out_q;
    burst_counter_d = burst_counter_q;
    wr_valid_d      = 1'b0;
    read_enable_d   = 1'b0;
    rx_done_d       = 1'b0;
    addr_err_d      = addr_err_q;
    beat            = 1'b0;
    beat_addr       = next_addr_q;
    beat_rem        = rem_q;
    in_range        = 1'b0;
    burst_eff       = (bus.burst == '0) ? BurstOne : bus.burst;

    unique case (state_q)
      StIdle: begin
        if (bus.master_valid && (bus.write_en ^ bus.read_en)) begin
          is_wr_d    = bus.write_en;
          addr_err_d = 1'b0;
          bit_cnt_d  = '0;
          addr_sh_d  = '0;
          data_sh_d  = '0;
          state_d    = StHdr;
        end
      end
      StHdr: begin
        // LSB-first: each new bit enters at the top and the word shifts down.
        addr_sh_d = (addr_sh_q >> 1) | (ADDR_WIDTH'(bus.rx_addr) << (ADDR_WIDTH - 1));
        if (is_wr_q && (32'(bit_cnt_q) < DATA_WIDTH)) begin
          data_sh_d = (data_sh_q >> 1) | (DATA_WIDTH'(bus.rx_data) << (DATA_WIDTH - 1));
        end
        if (bit_cnt_q == '0) begin
          rem_d = burst_eff;
        end
        bit_cnt_d = bit_cnt_q + CntWidth'(1);
        if (32'(bit_cnt_q) == ADDR_WIDTH - 1) begin
          bit_cnt_d = '0;
          if (is_wr_q) begin
            beat      = 1'b1;
            beat_addr = addr_sh_d;
            beat_rem  = rem_d;
          end else begin
            next_addr_d = addr_sh_d;
            state_d     = StRburst;
          end
        end
      end
      StWdata: begin
        data_sh_d = (data_sh_q >> 1) | (DATA_WIDTH'(bus.rx_data) << (DATA_WIDTH - 1));
        bit_cnt_d = bit_cnt_q + CntWidth'(1);
        if (32'(bit_cnt_q) == DATA_WIDTH - 1) begin
          bit_cnt_d = '0;
          beat      = 1'b1;
        end
      end
      StRburst: beat = 1'b1;
      StLast: begin
        rx_done_d = 1'b1;
        state_d   = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Common beat bookkeeping; out-of-range beats keep their timing but lose the strobe.
    if (beat) begin
      in_range        = (64'(beat_addr) < 64'(MEM_DEPTH));
      addr_out_d      = beat_addr;
      burst_counter_d = beat_rem - BurstOne;
      next_addr_d     = beat_addr + ADDR_WIDTH'(1);
      rem_d           = beat_rem - BurstOne;
      if (is_wr_q) begin
        data_out_d = data_sh_d;
        wr_valid_d = in_range;
      end else begin
        read_enable_d = in_range;
      end
      if (!in_range) begin
        addr_err_d = 1'b1;
      end
      if (beat_rem == BurstOne) begin
        state_d = StLast;
      end else begin
        state_d = is_wr_q ? StWdata : StRburst;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= StIdle;
      is_wr_q         <= 1'b0;
      bit_cnt_q       <= '0;
      addr_sh_q       <= '0;
      data_sh_q       <= '0;
      next_addr_q     <= '0;
      rem_q           <= '0;
      data_out_q      <= '0;
      addr_out_q      <= '0;
      burst_counter_q <= '0;
      wr_valid_q      <= 1'b0;
      read_enable_q   <= 1'b0;
      rx_done_q       <= 1'b0;
      addr_err_q      <= 1'b0;
    end else begin
      state_q         <= state_d;
      is_wr_q         <= is_wr_d;
      bit_cnt_q       <= bit_cnt_d;
      addr_sh_q       <= addr_sh_d;
      data_sh_q       <= data_sh_d;
      next_addr_q     <= next_addr_d;
      rem_q           <= rem_d;
      data_out_q      <= data_out_d;
      addr_out_q      <= addr_out_d;
      burst_counter_q <= burst_counter_d;
      wr_valid_q      <= wr_valid_d;
      read_enable_q   <= read_enable_d;
      rx_done_q       <= rx_done_d;
      addr_err_q      <= addr_err_d;
    end
  end

  assign bus.slave_ready   = (state_q == StIdle);
  assign bus.data_out      = data_out_q;
  assign bus.addr_out      = addr_out_q;
  assign bus.burst_counter = burst_counter_q;
  assign bus.wr_valid      = wr_valid_q;
  assign bus.read_enable   = read_enable_q;
  assign bus.rx_done       = rx_done_q;
  assign bus.addr_err      = addr_err_q;
endmodule

// File: tb/tb_slave_in_port_burst.sv
// Self-checking bench for slave_in_port_burst: two instances (MEM_DEPTH 4096 and 2048) share
// the same stimulus; every cycle's outputs are recorded and compared against a beat-timing
// model derived from the transaction parameters.
module tb_slave_in_port_burst;
  localparam int unsigned AW = 12;
  localparam int unsigned DW = 8;
  localparam int unsigned BW = 12;
  localparam int HN = 1024;

  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [DW-1:0] words [16];

  slave_in_port_burst_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WIDTH(BW)) bus0 ();
  slave_in_port_burst_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WIDTH(BW)) bus1 ();

  assign bus1.master_valid = bus0.master_valid;
  assign bus1.read_en      = bus0.read_en;
  assign bus1.write_en     = bus0.write_en;
  assign bus1.burst        = bus0.burst;
  assign bus1.rx_addr      = bus0.rx_addr;
  assign bus1.rx_data      = bus0.rx_data;

  slave_in_port_burst #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WIDTH(BW), .MEM_DEPTH(4096)
  ) dut0 (.clk(clk), .reset(reset), .bus(bus0));

  slave_in_port_burst #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST_WIDTH(BW), .MEM_DEPTH(2048)
  ) dut1 (.clk(clk), .reset(reset), .bus(bus1));

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // History of outputs, indexed by the number of the edge that produced them.
  logic [AW-1:0] h_addr [2][HN];
  logic [DW-1:0] h_data [2][HN];
  logic [BW-1:0] h_bc   [2][HN];
  logic          h_wv   [2][HN];
  logic          h_re   [2][HN];
  logic          h_done [2][HN];
  logic          h_rdy  [2][HN];
  logic          h_err  [2][HN];

  always @(negedge clk) begin
    h_addr[0][cyc % HN] <= bus0.addr_out;      h_addr[1][cyc % HN] <= bus1.addr_out;
    h_data[0][cyc % HN] <= bus0.data_out;      h_data[1][cyc % HN] <= bus1.data_out;
    h_bc[0][cyc % HN]   <= bus0.burst_counter; h_bc[1][cyc % HN]   <= bus1.burst_counter;
    h_wv[0][cyc % HN]   <= bus0.wr_valid;      h_wv[1][cyc % HN]   <= bus1.wr_valid;
    h_re[0][cyc % HN]   <= bus0.read_enable;   h_re[1][cyc % HN]   <= bus1.read_enable;
    h_done[0][cyc % HN] <= bus0.rx_done;       h_done[1][cyc % HN] <= bus1.rx_done;
    h_rdy[0][cyc % HN]  <= bus0.slave_ready;   h_rdy[1][cyc % HN]  <= bus1.slave_ready;
    h_err[0][cyc % HN]  <= bus0.addr_err;      h_err[1][cyc % HN]  <= bus1.addr_err;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive_idle();
    bus0.master_valid = 1'b0;
    bus0.write_en     = 1'($urandom);
    bus0.read_en      = 1'($urandom);
    bus0.burst        = BW'($urandom);
    bus0.rx_addr      = 1'($urandom);
    bus0.rx_data      = 1'($urandom);
  endtask

  // Edge at which beat k is strobed, relative to handshake edge t.
  function automatic int beat_edge(input bit wr, input int t, input int k);
    return wr ? t + int'(AW) + int'(DW) * k : t + int'(AW) + 1 + k;
  endfunction

  // Handshake plus serial header; t returns the handshake edge number.
  task automatic send_hdr(input bit wr, input logic [AW-1:0] base, input int nb_raw,
                          input bit poke, output int t);
    step();
    bus0.master_valid = 1'b1;
    bus0.write_en     = wr;
    bus0.read_en      = !wr;
    bus0.burst        = BW'(nb_raw);
    t = cyc + 1;
    for (int i = 0; i < int'(AW); i++) begin
      step();
      drive_idle();
      bus0.master_valid = poke && (i == 4);
      if (poke && i == 4) begin
        bus0.write_en = 1'b1;
        bus0.read_en  = 1'b0;
      end
      if (i == 0) bus0.burst = BW'(nb_raw);
      bus0.rx_addr = base[i];
      if (wr && i < int'(DW)) bus0.rx_data = words[0][i];
    end
  endtask

  task automatic verify(input bit wr, input int t, input int base, input int n);
    int last;
    last = beat_edge(wr, t, n - 1);
    for (int d = 0; d < 2; d++) begin
      int md;
      bit any_err;
      md = (d == 1) ? 2048 : 4096;
      any_err = 1'b0;
      for (int e = t; e <= last + 2; e++) begin
        int idx;
        int k;
        bit strobe;
        idx = e % HN;
        k = -1;
        strobe = 1'b0;
        for (int kk = 0; kk < n; kk++) if (beat_edge(wr, t, kk) == e) k = kk;
        if (k >= 0) begin
          int ba;
          ba = (base + k) % (1 << AW);
          strobe = (ba < md);
          if (!strobe) any_err = 1'b1;
          check_eq($sformatf("i%0d e+%0d addr_out", d, e - t), 32'(h_addr[d][idx]), 32'(ba));
          check_eq($sformatf("i%0d e+%0d burst_counter", d, e - t), 32'(h_bc[d][idx]),
                   32'(n - 1 - k));
          if (wr && strobe)
            check_eq($sformatf("i%0d e+%0d data_out", d, e - t), 32'(h_data[d][idx]),
                     32'(words[k]));
        end
        check_eq($sformatf("i%0d e+%0d wr_valid", d, e - t), 32'(h_wv[d][idx]),
                 32'(wr && strobe));
        check_eq($sformatf("i%0d e+%0d read_enable", d, e - t), 32'(h_re[d][idx]),
                 32'(!wr && strobe));
        check_eq($sformatf("i%0d e+%0d rx_done", d, e - t), 32'(h_done[d][idx]),
                 32'(e == last + 1));
        check_eq($sformatf("i%0d e+%0d slave_ready", d, e - t), 32'(h_rdy[d][idx]),
                 32'(e == last + 2));
        check_eq($sformatf("i%0d e+%0d addr_err", d, e - t), 32'(h_err[d][idx]),
                 32'(any_err));
      end
    end
  endtask

  task automatic run_txn(input bit wr, input logic [AW-1:0] base, input int nb_raw,
                         input bit poke, input bit rand_words);
    int n;
    int t;
    int last;
    int guard;
    n = (nb_raw == 0) ? 1 : nb_raw;
    if (rand_words) for (int k = 0; k < n; k++) words[k] = DW'($urandom);
    send_hdr(wr, base, nb_raw, poke, t);
    if (wr) begin
      for (int k = 1; k < n; k++) begin
        for (int b = 0; b < int'(DW); b++) begin
          step();
          drive_idle();
          bus0.rx_data = words[k][b];
        end
      end
    end
    last = beat_edge(wr, t, n - 1);
    guard = 0;
    while (cyc < last + 2 && guard < 200) begin
      step();
      drive_idle();
      guard++;
    end
    if (cyc < last + 2) check_eq("txn_timeout", 32'(cyc), 32'(last + 2));
    else verify(wr, t, int'(base), n);
  endtask

  initial begin
    int t;
    int r;
    int s0;
    reset = 1'b1;
    drive_idle();
    repeat (3) step();
    reset = 1'b0;
    // Reset state
    check_eq("rst slave_ready", 32'(bus0.slave_ready), 32'd1);
    check_eq("rst data_out", 32'(bus0.data_out), 32'd0);
    check_eq("rst addr_out", 32'(bus0.addr_out), 32'd0);
    check_eq("rst burst_counter", 32'(bus0.burst_counter), 32'd0);
    check_eq("rst strobes", 32'({bus0.wr_valid, bus0.read_enable, bus0.rx_done,
                                 bus0.addr_err}), 32'd0);
    repeat (2) step();

    // Single write, burst=0
    words[0] = 8'h55;
    run_txn(1'b1, 12'hAAA, 0, 1'b0, 1'b0);
    // Write burst N=3, back-to-back with the previous transaction
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33;
    run_txn(1'b1, 12'h010, 3, 1'b0, 1'b0);
    // Read burst wrapping past the top of the address space
    run_txn(1'b0, 12'hFFE, 4, 1'b0, 1'b1);
    // Range check straddling 2048
    run_txn(1'b1, 12'h7FF, 2, 1'b0, 1'b1);
    repeat (5) begin
      step();
      drive_idle();
    end
    check_eq("sticky addr_err i1", 32'(bus1.addr_err), 32'd1);
    check_eq("sticky addr_err i0", 32'(bus0.addr_err), 32'd0);

    // master_valid pulsed during the header is ignored
    run_txn(1'b1, 12'h345, 2, 1'b1, 1'b1);
    run_txn(1'b0, 12'h100, 3, 1'b1, 1'b1);

    // Reset during beat 1 of a 3-beat write
    for (int k = 0; k < 3; k++) words[k] = DW'($urandom);
    send_hdr(1'b1, 12'h123, 3, 1'b0, t);
    for (int b = 0; b < 3; b++) begin
      step();
      drive_idle();
      bus0.rx_data = words[1][b];
    end
    step();
    reset = 1'b1;
    r = cyc + 1;
    step();
    reset = 1'b0;
    drive_idle();
    for (int d = 0; d < 2; d++) begin
      check_eq($sformatf("i%0d abort addr_out", d), 32'(h_addr[d][r % HN]), 32'd0);
      check_eq($sformatf("i%0d abort data_out", d), 32'(h_data[d][r % HN]), 32'd0);
      check_eq($sformatf("i%0d abort burst_counter", d), 32'(h_bc[d][r % HN]), 32'd0);
      check_eq($sformatf("i%0d abort addr_err", d), 32'(h_err[d][r % HN]), 32'd0);
    end
    repeat (20) begin
      step();
      drive_idle();
    end
    for (int d = 0; d < 2; d++) begin
      for (int e = r; e < r + 20; e++) begin
        check_eq($sformatf("i%0d abort e+%0d strobes", d, e - r),
                 32'({h_wv[d][e % HN], h_re[d][e % HN], h_done[d][e % HN]}), 32'd0);
        check_eq($sformatf("i%0d abort e+%0d slave_ready", d, e - r),
                 32'(h_rdy[d][e % HN]), 32'd1);
      end
    end
    // Fresh write after the abort
    run_txn(1'b1, 12'h456, 3, 1'b0, 1'b1);

    // Illegal requests: both enables, then neither
    for (int mode = 0; mode < 2; mode++) begin
      step();
      drive_idle();
      bus0.master_valid = 1'b1;
      bus0.write_en     = (mode == 0);
      bus0.read_en      = (mode == 0);
      s0 = cyc + 1;
      repeat (6) begin
        step();
        bus0.master_valid = 1'b1;
        bus0.rx_addr      = 1'($urandom);
        bus0.rx_data      = 1'($urandom);
      end
      for (int e = s0; e < s0 + 6; e++) begin
        check_eq($sformatf("illegal%0d e+%0d slave_ready", mode, e - s0),
                 32'(h_rdy[0][e % HN]), 32'd1);
        check_eq($sformatf("illegal%0d e+%0d strobes", mode, e - s0),
                 32'({h_wv[0][e % HN], h_re[0][e % HN], h_done[0][e % HN]}), 32'd0);
      end
      drive_idle();
    end

    // Randomised transactions
    for (int i = 0; i < 10; i++) begin
      logic [AW-1:0] base;
      case ($urandom_range(2))
        0:       base = AW'(12'hFFD + $urandom_range(3));
        1:       base = AW'(12'h7FD + $urandom_range(3));
        default: base = AW'($urandom);
      endcase
      run_txn(1'($urandom), base, $urandom_range(5), 1'($urandom), 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
